// File: rtl/esn_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : esn_step_sequencer
// Description : Upstream/feedback stage of the reservoir PE. Stores the
//               synapse bank and reservoir state x(t), collects the serial
//               input samples u(t), enables the PE for PE_LAT cycles, captures
//               x(t+1) and hands it downstream with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module esn_step_sequencer #(
    parameter int WORD_LEN = 16,
    parameter int NEU_IN   = 8,
    parameter int NEU_OUT  = 4,
    parameter int PE_LAT   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                u_valid,
    output logic                                u_ready,
    input  logic [WORD_LEN-1:0]                 u_data,
    input  logic                                w_we,
    input  logic [4:0]                          w_addr,
    input  logic [WORD_LEN-1:0]                 w_data,
    input  logic                                clr_state,
    output logic                                pe_ce,
    output logic [WORD_LEN*NEU_IN-1:0]          pe_data,
    output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  pe_weight,
    input  logic [WORD_LEN*NEU_OUT-1:0]         pe_q,
    output logic                                x_valid,
    input  logic                                x_ready,
    output logic [WORD_LEN*NEU_OUT-1:0]         x_data,
    output logic                                busy
);

    // Input samples fill the PE inputs not used by the state feedback
    localparam int U_WORDS = NEU_IN - NEU_OUT;
    localparam int N_SYN   = NEU_IN * NEU_OUT;
    localparam int CNT_W   = (U_WORDS > 1) ? $clog2(U_WORDS) : 1;
    localparam int RUN_W   = 4;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(U_WORDS - 1);
    localparam logic [RUN_W-1:0] c_RUN_LAST = RUN_W'(PE_LAT - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_RUN     = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [RUN_W-1:0]      r_run_cnt;
    logic [WORD_LEN-1:0]   r_u     [U_WORDS];
    logic [WORD_LEN-1:0]   r_x     [NEU_OUT];
    logic [WORD_LEN-1:0]   r_wbank [N_SYN];

    logic                  w_u_accept;
    logic                  w_run_done;
    logic                  w_w_allow;
    logic                  w_clr_ok;

    assign w_u_accept = u_valid && (r_state == S_COLLECT);
    assign w_run_done = (r_state == S_RUN) && (r_run_cnt == c_RUN_LAST);
    assign w_w_allow  = w_we && (r_state != S_RUN);
    assign w_clr_ok   = clr_state && (r_state == S_COLLECT) && (r_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs; outputs are forced low while in reset
    always_comb begin
        w_state_nxt = r_state;
        u_ready     = 1'b0;
        pe_ce       = 1'b0;
        x_valid     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_COLLECT: begin
                u_ready = !rst;
                if (w_u_accept && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                pe_ce = !rst;
                busy  = !rst;
                if (w_run_done) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                x_valid = !rst;
                if (x_ready) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Sample counter and PE latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_run_cnt <= '0;
        end else begin
            if (w_u_accept) begin
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            if (r_state == S_RUN) begin
                r_run_cnt <= w_run_done ? '0 : r_run_cnt + RUN_W'(1);
            end
        end
    end

    // Input sample buffer, written in arrival order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < U_WORDS; i++) begin
                r_u[i] <= '0;
            end
        end else if (w_u_accept) begin
            r_u[r_cnt] <= u_data;
        end
    end

    // Synapse bank; writes during RUN are dropped so the PE sees stable weights
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                r_wbank[i] <= '0;
            end
        end else if (w_w_allow) begin
            r_wbank[w_addr] <= w_data;
        end
    end

    // Reservoir state: captures PE output at the end of RUN, or clears between steps
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NEU_OUT; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_run_done) begin
            for (int i = 0; i < NEU_OUT; i++) begin
                r_x[i] <= pe_q[i*WORD_LEN +: WORD_LEN];
            end
        end else if (w_clr_ok) begin
            for (int i = 0; i < NEU_OUT; i++) begin
                r_x[i] <= '0;
            end
        end
    end

    generate
        for (genvar i = 0; i < U_WORDS; i++) begin : g_pe_data_u
            assign pe_data[i*WORD_LEN +: WORD_LEN] = r_u[i];
        end
        for (genvar i = 0; i < NEU_OUT; i++) begin : g_pe_data_x
            assign pe_data[(U_WORDS+i)*WORD_LEN +: WORD_LEN] = r_x[i];
            assign x_data[i*WORD_LEN +: WORD_LEN]            = r_x[i];
        end
        for (genvar i = 0; i < N_SYN; i++) begin : g_pe_weight
            assign pe_weight[i*WORD_LEN +: WORD_LEN] = r_wbank[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_esn_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_esn_step_sequencer
// Description : Self-checking bench for esn_step_sequencer: directed vector
//               table, hand-written corner sequences and randomized traffic
//               against a step-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esn_step_sequencer;

    localparam int PE_LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         u_valid = 1'b0;
    logic         u_ready;
    logic [15:0]  u_data = '0;
    logic         w_we = 1'b0;
    logic [4:0]   w_addr = '0;
    logic [15:0]  w_data = '0;
    logic         clr_state = 1'b0;
    logic         pe_ce;
    logic [127:0] pe_data;
    logic [511:0] pe_weight;
    logic [63:0]  pe_q = '0;
    logic         x_valid;
    logic         x_ready = 1'b0;
    logic [63:0]  x_data;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    esn_step_sequencer #(
        .WORD_LEN(16), .NEU_IN(8), .NEU_OUT(4), .PE_LAT(PE_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .u_valid(u_valid), .u_ready(u_ready), .u_data(u_data),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .clr_state(clr_state),
        .pe_ce(pe_ce), .pe_data(pe_data), .pe_weight(pe_weight), .pe_q(pe_q),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: step phase (0 collect, 1 run, 2 output), samples taken,
    // cycles left in the PE run, and the three storage arrays.
    int          m_phase;
    int          m_got;
    int          m_left;
    logic [15:0] m_u [4];
    logic [15:0] m_x [4];
    logic [15:0] m_w [32];

    task automatic model_reset();
        m_phase = 0; m_got = 0; m_left = 0;
        for (int i = 0; i < 4; i++) begin m_u[i] = '0; m_x[i] = '0; end
        for (int i = 0; i < 32; i++) m_w[i] = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (w_we) m_w[w_addr] = w_data;
                    if (clr_state && m_got == 0)
                        for (int i = 0; i < 4; i++) m_x[i] = '0;
                    if (u_valid) begin
                        m_u[m_got] = u_data;
                        m_got++;
                        if (m_got == 4) begin m_got = 0; m_phase = 1; m_left = PE_LAT; end
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        for (int i = 0; i < 4; i++) m_x[i] = pe_q[i*16 +: 16];
                        m_phase = 2;
                    end
                end
                default: begin
                    if (w_we) m_w[w_addr] = w_data;
                    if (x_ready) m_phase = 0;
                end
            endcase
        end
    endtask

    function automatic logic [63:0] exp_x();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = m_x[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_pe_data();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*16 +: 16]      = m_u[i];
            r[(i+4)*16 +: 16]  = m_x[i];
        end
        return r;
    endfunction

    function automatic logic [511:0] exp_w();
        logic [511:0] r;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = m_w[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: advance the model at the edge, then compare all outputs
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("u_ready",   u_ready,   (m_phase == 0) && !rst);
        check("pe_ce",     pe_ce,     (m_phase == 1) && !rst);
        check("busy",      busy,      (m_phase == 1) && !rst);
        check("x_valid",   x_valid,   (m_phase == 2) && !rst);
        check("x_data",    x_data,    exp_x());
        check("pe_data",   pe_data,   exp_pe_data());
        check("pe_weight", pe_weight, exp_w());
    endtask

    task automatic send(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            u_valid = 1'b1; u_data = base + 16'(i);
            tick();
        end
        u_valid = 1'b0;
    endtask

    task automatic run_wait();
        for (int i = 0; i < PE_LAT; i++) tick();
    endtask

    typedef struct {
        bit          rst;
        bit          uv;
        logic [15:0] ud;
        bit          we;
        logic [4:0]  wa;
        logic [15:0] wd;
        bit          clr;
        bit          xr;
        bit          e_urdy;
        bit          e_ce;
        bit          e_xv;
        bit          e_busy;
    } vec_t;

    function automatic vec_t mk(bit r, bit uv, logic [15:0] ud, bit we, logic [4:0] wa,
                                logic [15:0] wd, bit clr, bit xr,
                                bit eu, bit ec, bit ex, bit eb);
        vec_t v;
        v.rst = r; v.uv = uv; v.ud = ud; v.we = we; v.wa = wa; v.wd = wd;
        v.clr = clr; v.xr = xr; v.e_urdy = eu; v.e_ce = ec; v.e_xv = ex; v.e_busy = eb;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] held;
        model_reset();

        vecs[0] = mk(1, 0, 16'h0000, 0, 5'd0, 16'h0000, 0, 0,  0, 0, 0, 0);
        vecs[1] = mk(1, 0, 16'h0000, 0, 5'd0, 16'h0000, 0, 0,  0, 0, 0, 0);
        vecs[2] = mk(0, 0, 16'h0000, 0, 5'd0, 16'h0000, 0, 0,  1, 0, 0, 0);
        vecs[3] = mk(0, 0, 16'h0000, 1, 5'd9, 16'h1234, 0, 0,  1, 0, 0, 0);
        vecs[4] = mk(0, 1, 16'h0001, 0, 5'd0, 16'h0000, 0, 0,  1, 0, 0, 0);
        vecs[5] = mk(0, 1, 16'h0002, 0, 5'd0, 16'h0000, 0, 0,  1, 0, 0, 0);
        vecs[6] = mk(0, 1, 16'h0003, 0, 5'd0, 16'h0000, 0, 0,  1, 0, 0, 0);
        vecs[7] = mk(0, 1, 16'h0004, 0, 5'd0, 16'h0000, 0, 0,  0, 1, 0, 1);
        vecs[8] = mk(0, 1, 16'hFFFF, 1, 5'd9, 16'h5678, 0, 0,  0, 1, 0, 1);
        vecs[9] = mk(0, 1, 16'hEEEE, 0, 5'd0, 16'h0000, 0, 0,  0, 0, 1, 0);

        pe_q = 64'h4000_3000_2000_1000;

        // Directed table: reset, weight write, single step (write dropped in RUN)
        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst; u_valid = vecs[i].uv; u_data = vecs[i].ud;
            w_we = vecs[i].we; w_addr = vecs[i].wa; w_data = vecs[i].wd;
            clr_state = vecs[i].clr; x_ready = vecs[i].xr;
            tick();
            check("tbl_u_ready", u_ready, vecs[i].e_urdy);
            check("tbl_pe_ce",   pe_ce,   vecs[i].e_ce);
            check("tbl_x_valid", x_valid, vecs[i].e_xv);
            check("tbl_busy",    busy,    vecs[i].e_busy);
            if (i == 2) begin
                check("reset_pe_data",   pe_data,   '0);
                check("reset_pe_weight", pe_weight, '0);
                check("reset_x_data",    x_data,    '0);
            end
            if (i == 3) check("wr_addr9", pe_weight, 512'h1234 << 144);
            if (i == 7) begin
                check("pe_data_u", pe_data[63:0],   64'h0004_0003_0002_0001);
                check("pe_data_x", pe_data[127:64], 64'h0);
            end
            if (i == 8) check("wr_in_run_dropped", pe_weight[159:144], 16'h1234);
            if (i == 9) check("x_capture", x_data, 64'h4000_3000_2000_1000);
        end
        w_we = 1'b0;

        // Back-pressure: downstream stalls while upstream keeps offering data
        x_ready = 1'b0; u_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            u_data = 16'($urandom);
            tick();
            check("bp_u_ready", u_ready, 1'b0);
            check("bp_pe_ce",   pe_ce,   1'b0);
        end
        check("bp_x_hold",  x_data,         64'h4000_3000_2000_1000);
        check("bp_u_hold",  pe_data[63:0],  64'h0004_0003_0002_0001);
        u_valid = 1'b0; x_ready = 1'b1;
        tick();
        check("hs_u_ready", u_ready, 1'b1);
        x_ready = 1'b0;

        // Recurrence: previous state feeds PE inputs 4..7
        pe_q = 64'hAAAA_BBBB_CCCC_DDDD;
        send(4, 16'h0005);
        check("recur_x_on_pe", pe_data[127:64], 64'h4000_3000_2000_1000);
        run_wait();
        check("recur_x_new", x_data, 64'hAAAA_BBBB_CCCC_DDDD);
        x_ready = 1'b1; tick(); x_ready = 1'b0;

        // Clear ignored mid-collection, honoured at a step boundary
        send(2, 16'h0100);
        clr_state = 1'b1; tick(); clr_state = 1'b0;
        check("clr_cnt2_ignored", x_data, 64'hAAAA_BBBB_CCCC_DDDD);
        pe_q = 64'h0123_4567_89AB_CDEF;
        send(2, 16'h0102);
        run_wait();
        x_ready = 1'b1; tick(); x_ready = 1'b0;
        check("pre_clr_x", x_data, 64'h0123_4567_89AB_CDEF);
        clr_state = 1'b1; tick(); clr_state = 1'b0;
        check("clr_cnt0", x_data, 64'h0);

        // Reset in the first RUN cycle discards the step and the weight bank
        send(4, 16'h0200);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_pe_ce",  pe_ce,     1'b0);
        check("midrst_busy",   busy,      1'b0);
        check("midrst_x",      x_data,    64'h0);
        check("midrst_weight", pe_weight, '0);
        tick();
        check("midrst_collect", u_ready, 1'b1);
        pe_q = 64'h7FFF_8000_0001_FFFF;
        send(4, 16'h0300);
        run_wait();
        check("post_rst_xv", x_valid, 1'b1);
        check("post_rst_x",  x_data,  64'h7FFF_8000_0001_FFFF);
        held = x_data;
        x_ready = 1'b1; tick(); x_ready = 1'b0;
        check("post_rst_held", x_data, held);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            u_valid   = ($urandom_range(0, 9) < 7);
            u_data    = 16'($urandom);
            w_we      = ($urandom_range(0, 4) == 0);
            w_addr    = 5'($urandom);
            w_data    = 16'($urandom);
            clr_state = ($urandom_range(0, 9) == 0);
            x_ready   = ($urandom_range(0, 9) < 6);
            pe_q      = {32'($urandom), 32'($urandom)};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
